// File: rtl/dct4_transpose_buf_pkg.sv
// Shared types and constants for the 4x4 DCT transpose buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dct4_transpose_buf_pkg;

  // Packed float {sign, exp[7:0], mant[23:0]}; carried opaquely, never decoded.
  localparam int FW       = 33;
  localparam int SIGN_BIT = 32;
  localparam int EXP_MSB  = 31;
  localparam int EXP_LSB  = 24;
  localparam int MANT_MSB = 23;

  // Tile dimension; the control logic assumes 2-bit row/column pointers.
  localparam int N = 4;

  typedef logic [FW-1:0] flt_t;

  // +1.0 in the packed float format (explicit leading one in the mantissa).
  localparam flt_t ONE = {1'b0, 8'h7F, 24'h800000};

endpackage

// File: rtl/dct4_tile_bank.sv
// One 4x4 float register bank: row-wide write port, column-wide read mux.
// Latency: write lands on the clock edge; read is combinational from storage.
// Backpressure: none; the owner decides when to write and which column to show.
module dct4_tile_bank
  import dct4_transpose_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [1:0] i_wr_row,
  input  flt_t       i_wr_d0,
  input  flt_t       i_wr_d1,
  input  flt_t       i_wr_d2,
  input  flt_t       i_wr_d3,
  input  logic [1:0] i_rd_col,
  output flt_t       o_rd_d0,
  output flt_t       o_rd_d1,
  output flt_t       o_rd_d2,
  output flt_t       o_rd_d3
);

  flt_t r_mem [N][N];

  // Storage: cleared by async reset, otherwise one full row written per enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_wr_row][0] <= i_wr_d0;
      r_mem[i_wr_row][1] <= i_wr_d1;
      r_mem[i_wr_row][2] <= i_wr_d2;
      r_mem[i_wr_row][3] <= i_wr_d3;
    end
  end

  // Column read: element k of the output is row k of the selected column.
  assign o_rd_d0 = r_mem[0][i_rd_col];
  assign o_rd_d1 = r_mem[1][i_rd_col];
  assign o_rd_d2 = r_mem[2][i_rd_col];
  assign o_rd_d3 = r_mem[3][i_rd_col];

endmodule

// File: rtl/dct4_transpose_buf.sv
// Ping-pong 4x4 transpose buffer: rows in, columns out, two banks alternate.
// Latency: first column valid the cycle after the 4th row of a tile is accepted.
// Backpressure: in_ready drops while the write bank is full; outputs hold while out_ready is low.
module dct4_transpose_buf
  import dct4_transpose_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  flt_t       in_d0,
  input  flt_t       in_d1,
  input  flt_t       in_d2,
  input  flt_t       in_d3,
  output logic       out_valid,
  input  logic       out_ready,
  output flt_t       out_d0,
  output flt_t       out_d1,
  output flt_t       out_d2,
  output flt_t       out_d3,
  output logic [1:0] out_col,
  output logic       out_last
);

  logic       r_wr_bank;
  logic [1:0] r_wr_row;
  logic       r_rd_bank;
  logic [1:0] r_rd_col;
  logic [1:0] r_full;

  logic       w_wr_acc;
  logic       w_rd_acc;
  logic [1:0] w_full_nxt;
  logic       w_we0;
  logic       w_we1;
  flt_t       w_b0_d0, w_b0_d1, w_b0_d2, w_b0_d3;
  flt_t       w_b1_d0, w_b1_d1, w_b1_d2, w_b1_d3;

  assign in_ready  = ~r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign w_wr_acc  = in_valid & in_ready;
  assign w_rd_acc  = out_valid & out_ready;

  // A flushed write must not touch storage either, so the bank enables are gated too.
  assign w_we0 = w_wr_acc & ~flush & ~r_wr_bank;
  assign w_we1 = w_wr_acc & ~flush &  r_wr_bank;

  // Full flags: set on the last row written, cleared on the last column read.
  // Both may happen in one cycle; they always hit different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_acc && (r_wr_row == 2'd3)) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_acc && (r_rd_col == 2'd3)) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Pointer and flag registers; flush wins over any accept in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_row  <= 2'd0;
      r_rd_bank <= 1'b0;
      r_rd_col  <= 2'd0;
      r_full    <= 2'b00;
    end else if (flush) begin
      r_wr_bank <= 1'b0;
      r_wr_row  <= 2'd0;
      r_rd_bank <= 1'b0;
      r_rd_col  <= 2'd0;
      r_full    <= 2'b00;
    end else begin
      if (w_wr_acc) begin
        r_wr_row <= r_wr_row + 2'd1;
        if (r_wr_row == 2'd3) r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_acc) begin
        r_rd_col <= r_rd_col + 2'd1;
        if (r_rd_col == 2'd3) r_rd_bank <= ~r_rd_bank;
      end
      r_full <= w_full_nxt;
    end
  end

  dct4_tile_bank u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we0),
    .i_wr_row (r_wr_row),
    .i_wr_d0  (in_d0),
    .i_wr_d1  (in_d1),
    .i_wr_d2  (in_d2),
    .i_wr_d3  (in_d3),
    .i_rd_col (r_rd_col),
    .o_rd_d0  (w_b0_d0),
    .o_rd_d1  (w_b0_d1),
    .o_rd_d2  (w_b0_d2),
    .o_rd_d3  (w_b0_d3)
  );

  dct4_tile_bank u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we1),
    .i_wr_row (r_wr_row),
    .i_wr_d0  (in_d0),
    .i_wr_d1  (in_d1),
    .i_wr_d2  (in_d2),
    .i_wr_d3  (in_d3),
    .i_rd_col (r_rd_col),
    .o_rd_d0  (w_b1_d0),
    .o_rd_d1  (w_b1_d1),
    .o_rd_d2  (w_b1_d2),
    .o_rd_d3  (w_b1_d3)
  );

  // Present the read bank's current column.
  assign out_d0   = r_rd_bank ? w_b1_d0 : w_b0_d0;
  assign out_d1   = r_rd_bank ? w_b1_d1 : w_b0_d1;
  assign out_d2   = r_rd_bank ? w_b1_d2 : w_b0_d2;
  assign out_d3   = r_rd_bank ? w_b1_d3 : w_b0_d3;
  assign out_col  = r_rd_col;
  assign out_last = out_valid & (r_rd_col == 2'd3);

endmodule

// File: tb/tb_dct4_transpose_buf.sv
// Directed bench for the ping-pong transpose buffer.
// Latency: drives after each rising edge, samples on the falling edge.
// Backpressure: exercises stalls, full banks, flush and async reset.
module tb_dct4_transpose_buf;
  import dct4_transpose_buf_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  flt_t       in_d0, in_d1, in_d2, in_d3;
  logic       out_valid;
  logic       out_ready;
  flt_t       out_d0, out_d1, out_d2, out_d3;
  logic [1:0] out_col;
  logic       out_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dct4_transpose_buf dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d0     (in_d0),
    .in_d1     (in_d1),
    .in_d2     (in_d2),
    .in_d3     (in_d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_d3    (out_d3),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  // Element (r,c) of tile 'tag': mantissa LSBs = tag*16 + r*4 + c.
  function automatic flt_t elem(input int tag, input int r, input int c);
    logic [23:0] m;
    m = 24'h800000 | 24'(tag * 16 + r * 4 + c);
    return {1'b0, 8'h7F, m};
  endfunction

  task automatic drive_row(input logic v, input int tag, input int r);
    in_valid = v;
    in_d0 = elem(tag, r, 0);
    in_d1 = elem(tag, r, 1);
    in_d2 = elem(tag, r, 2);
    in_d3 = elem(tag, r, 3);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tile(input int tag);
    for (int r = 0; r < 4; r++) begin
      drive_row(1'b1, tag, r);
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_col !== 2'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_col=%0d out_last=%b, want 1 0 0 0",
               in_ready, out_valid, out_col, out_last);
    end
    n_checks++;
    if (out_d0 !== '0 || out_d1 !== '0 || out_d2 !== '0 || out_d3 !== '0) begin
      n_fail++;
      $display("FAIL reset_data: out_d=%h %h %h %h, want all 0", out_d0, out_d1, out_d2, out_d3);
    end
    next_cycle();
  endtask

  task automatic test_single_tile();
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      drive_row(1'b1, 0, r);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tile_fill row %0d: in_ready=%b out_valid=%b, want 1 0", r, in_ready, out_valid);
      end
      next_cycle();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_col !== 2'(c) || out_last !== (c == 3)) begin
        n_fail++;
        $display("FAIL tile_ctrl col %0d: out_valid=%b out_col=%0d out_last=%b", c, out_valid, out_col, out_last);
      end
      n_checks++;
      if (out_d0 !== elem(0, 0, c) || out_d1 !== elem(0, 1, c) ||
          out_d2 !== elem(0, 2, c) || out_d3 !== elem(0, 3, c)) begin
        n_fail++;
        $display("FAIL tile_data col %0d: got %h %h %h %h, want %h %h %h %h", c,
                 out_d0, out_d1, out_d2, out_d3,
                 elem(0, 0, c), elem(0, 1, c), elem(0, 2, c), elem(0, 3, c));
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tile_drained: out_valid=%b, want 0", out_valid);
    end
    next_cycle();
  endtask

  task automatic test_streaming();
    int out_cnt;
    out_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 12) drive_row(1'b1, 1 + i / 4, i % 4);
      else in_valid = 1'b0;
      @(negedge clk);
      if (i < 12) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_in_ready cycle %0d: got %b, want 1", i, in_ready);
        end
      end
      n_checks++;
      if (out_valid !== (i >= 4 && i < 16)) begin
        n_fail++;
        $display("FAIL stream_out_valid cycle %0d: got %b, want %b", i, out_valid, (i >= 4 && i < 16));
      end
      if (out_valid === 1'b1 && out_cnt < 12) begin
        n_checks++;
        if (out_col !== 2'(out_cnt % 4) ||
            out_d0 !== elem(1 + out_cnt / 4, 0, out_cnt % 4) ||
            out_d1 !== elem(1 + out_cnt / 4, 1, out_cnt % 4) ||
            out_d2 !== elem(1 + out_cnt / 4, 2, out_cnt % 4) ||
            out_d3 !== elem(1 + out_cnt / 4, 3, out_cnt % 4)) begin
          n_fail++;
          $display("FAIL stream_col %0d: col=%0d d0=%h d3=%h, want col=%0d d0=%h d3=%h", out_cnt,
                   out_col, out_d0, out_d3, out_cnt % 4,
                   elem(1 + out_cnt / 4, 0, out_cnt % 4), elem(1 + out_cnt / 4, 3, out_cnt % 4));
        end
        out_cnt++;
      end
      next_cycle();
    end
    n_checks++;
    if (out_cnt !== 12) begin
      n_fail++;
      $display("FAIL stream_count: got %0d columns, want 12", out_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    // Rows 0..7 fill both banks; rows 8,9 must be ignored.
    for (int i = 0; i < 10; i++) begin
      drive_row(1'b1, 4 + i / 4, i % 4);
      @(negedge clk);
      n_checks++;
      if (in_ready !== (i < 8)) begin
        n_fail++;
        $display("FAIL bp_in_ready row %0d: got %b, want %b", i, in_ready, (i < 8));
      end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      if (j < 4) drive_row(1'b1, 9, j);
      else in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== (j >= 4)) begin
        n_fail++;
        $display("FAIL bp_drain_in_ready beat %0d: got %b, want %b", j, in_ready, (j >= 4));
      end
      if (j < 8) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_col !== 2'(j % 4) ||
            out_d0 !== elem(4 + j / 4, 0, j % 4) || out_d1 !== elem(4 + j / 4, 1, j % 4) ||
            out_d2 !== elem(4 + j / 4, 2, j % 4) || out_d3 !== elem(4 + j / 4, 3, j % 4)) begin
          n_fail++;
          $display("FAIL bp_drain_col beat %0d: vld=%b col=%0d d0=%h d3=%h, want col=%0d d0=%h d3=%h",
                   j, out_valid, out_col, out_d0, out_d3, j % 4,
                   elem(4 + j / 4, 0, j % 4), elem(4 + j / 4, 3, j % 4));
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_drained: out_valid=%b, want 0", out_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall_hold();
    logic rdy_pat [7];
    int   col_exp [7];
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    col_exp = '{0, 1, 2, 2, 2, 2, 3};
    out_ready = 1'b0;
    write_tile(6);
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy_pat[i];
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_col !== 2'(col_exp[i]) || out_last !== (col_exp[i] == 3) ||
          out_d0 !== elem(6, 0, col_exp[i]) || out_d1 !== elem(6, 1, col_exp[i]) ||
          out_d2 !== elem(6, 2, col_exp[i]) || out_d3 !== elem(6, 3, col_exp[i])) begin
        n_fail++;
        $display("FAIL stall_hold step %0d: vld=%b col=%0d last=%b d0=%h, want col=%0d last=%b d0=%h",
                 i, out_valid, out_col, out_last, out_d0, col_exp[i], (col_exp[i] == 3),
                 elem(6, 0, col_exp[i]));
      end
      next_cycle();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive_row(1'b1, 7, 0);
    next_cycle();
    drive_row(1'b1, 7, 1);
    next_cycle();
    // Flush coincides with an offered row: flush must win.
    drive_row(1'b1, 7, 2);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_col !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_ctrl: out_valid=%b in_ready=%b out_col=%0d, want 0 1 0", out_valid, in_ready, out_col);
    end
    next_cycle();
    in_d0 = ONE; in_d1 = ONE; in_d2 = ONE; in_d3 = ONE;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_refill row %0d: out_valid=%b, want 0", r, out_valid);
      end
      next_cycle();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_col !== 2'(c) ||
          out_d0 !== ONE || out_d1 !== ONE || out_d2 !== ONE || out_d3 !== ONE) begin
        n_fail++;
        $display("FAIL flush_tile col %0d: vld=%b col=%0d d=%h %h %h %h, want all %h",
                 c, out_valid, out_col, out_d0, out_d1, out_d2, out_d3, ONE);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    write_tile(3);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_d0 !== elem(3, 0, 0)) begin
      n_fail++;
      $display("FAIL arst_pre: out_valid=%b d0=%h, want 1 %h", out_valid, out_d0, elem(3, 0, 0));
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_d0 !== '0 || out_d1 !== '0 || out_d2 !== '0 || out_d3 !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: out_valid=%b in_ready=%b d=%h %h %h %h, want 0 1 and zeros",
               out_valid, in_ready, out_d0, out_d1, out_d2, out_d3);
    end
    next_cycle();
    rst = 1'b0;
    // Pointers restart: a fresh tile comes back out from column 0 of bank 0.
    out_ready = 1'b1;
    write_tile(2);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_col !== 2'd0 || out_d2 !== elem(2, 2, 0)) begin
      n_fail++;
      $display("FAIL arst_restart: vld=%b col=%0d d2=%h, want 1 0 %h", out_valid, out_col, out_d2, elem(2, 2, 0));
    end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_d0 = '0; in_d1 = '0; in_d2 = '0; in_d3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_tile();
    test_streaming();
    test_backpressure();
    test_stall_hold();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
